// File: rtl/cp0_regfile.sv
// CP0 system-control registers: BadVAddr, Count, Compare, Status, Cause, EPC, plus interrupt request.
// Optional Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_regfile #(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_ena,
    input  logic [4:0]  w_addr,
    input  logic [2:0]  w_sel,
    input  logic [31:0] w_data,
    input  logic [4:0]  r_addr,
    input  logic [2:0]  r_sel,
    output logic [31:0] r_data,
    input  logic [5:0]  ext_int,
    input  logic        w_cp0_update_ena,
    input  logic [4:0]  w_cp0_exccode,
    input  logic        w_cp0_bd,
    input  logic        w_cp0_exl,
    input  logic [31:0] w_cp0_epc,
    input  logic        w_cp0_badvaddr_ena,
    input  logic [31:0] w_cp0_badvaddr,
    input  logic        cp0_cls_exl,
    output logic [31:0] r_cp0_epc,
    output logic [31:0] r_cp0_status,
    output logic [31:0] r_cp0_cause,
    output logic        cp0_int_req
);
    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_STATUS   = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;

    logic [31:0] r_badvaddr;
    logic [31:0] r_epc;
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip_hw;
    logic [1:0]  r_cause_ip_sw;
    logic [4:0]  r_cause_exccode;

    logic        w_mtc0;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [31:0] w_status_val;
    logic [31:0] w_cause_val;
    logic [31:0] w_rdata;

    assign w_mtc0      = w_ena & (w_sel == 3'd0);
    assign w_wr_status = w_mtc0 & (w_addr == A_STATUS);
    assign w_wr_cause  = w_mtc0 & (w_addr == A_CAUSE);
    assign w_wr_epc    = w_mtc0 & (w_addr == A_EPC);

`ifdef CP0_TIMER_EN
    localparam int TICK_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(COUNT_DIV - 1);

    logic [31:0]       r_count;
    logic [31:0]       r_compare;
    logic [TICK_W-1:0] r_tick;
    logic              r_ti;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_tick    <= '0;
            r_ti      <= 1'b0;
        end else begin
            if (w_mtc0 && w_addr == A_COUNT) begin
                r_count <= w_data;
                r_tick  <= '0;
            end else if (r_tick == TICK_MAX) begin
                r_count <= r_count + 32'd1;
                r_tick  <= '0;
            end else begin
                r_tick  <= r_tick + 1'b1;
            end
            if (w_mtc0 && w_addr == A_COMPARE)
                r_compare <= w_data;
            // A match in the same cycle as a Compare write keeps TI set.
            if (r_count == r_compare)
                r_ti <= 1'b1;
            else if (w_mtc0 && w_addr == A_COMPARE)
                r_ti <= 1'b0;
        end
    end

    assign w_ti      = r_ti;
    assign w_count   = r_count;
    assign w_compare = r_compare;
`else
    assign w_ti      = 1'b0;
    assign w_count   = 32'd0;
    assign w_compare = 32'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_badvaddr      <= 32'd0;
            r_epc           <= 32'd0;
            r_status_im     <= STATUS_RST[15:8];
            r_status_exl    <= STATUS_RST[1];
            r_status_ie     <= STATUS_RST[0];
            r_cause_bd      <= 1'b0;
            r_cause_ip_hw   <= 6'd0;
            r_cause_ip_sw   <= 2'd0;
            r_cause_exccode <= 5'd0;
        end else begin
            r_cause_ip_hw <= {ext_int[5] | w_ti, ext_int[4:0]};
            if (w_wr_status) begin
                r_status_im <= w_data[15:8];
                r_status_ie <= w_data[0];
            end
            if (w_wr_cause)
                r_cause_ip_sw <= w_data[9:8];
            // EXL: exception commit beats ERET, which beats MTC0.
            if (w_cp0_update_ena)
                r_status_exl <= w_cp0_exl;
            else if (cp0_cls_exl)
                r_status_exl <= 1'b0;
            else if (w_wr_status)
                r_status_exl <= w_data[1];
            if (w_cp0_update_ena) begin
                r_cause_exccode <= w_cp0_exccode;
                // Nested exceptions keep the original victim PC and BD.
                if (!r_status_exl) begin
                    r_epc      <= w_cp0_epc;
                    r_cause_bd <= w_cp0_bd;
                end
                if (w_cp0_badvaddr_ena)
                    r_badvaddr <= w_cp0_badvaddr;
            end else if (w_wr_epc) begin
                r_epc <= w_data;
            end
        end
    end

    assign w_status_val = {9'd0, STATUS_RST[22], 6'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
    assign w_cause_val  = {r_cause_bd, w_ti, 14'd0, r_cause_ip_hw, r_cause_ip_sw, 1'b0, r_cause_exccode, 2'd0};

    always_comb begin
        w_rdata = 32'd0;
        if (r_sel == 3'd0) begin
            case (r_addr)
                A_BADVADDR: w_rdata = r_badvaddr;
                A_COUNT:    w_rdata = w_count;
                A_COMPARE:  w_rdata = w_compare;
                A_STATUS:   w_rdata = w_status_val;
                A_CAUSE:    w_rdata = w_cause_val;
                A_EPC:      w_rdata = r_epc;
                default:    w_rdata = 32'd0;
            endcase
        end
    end

    assign r_data       = w_rdata;
    assign r_cp0_epc    = r_epc;
    assign r_cp0_status = w_status_val;
    assign r_cp0_cause  = w_cause_val;
    assign cp0_int_req  = r_status_ie & ~r_status_exl &
                          (|(r_status_im & {r_cause_ip_hw, r_cause_ip_sw}));
endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: expectations are queued when stimulus is driven
// and compared one cycle later; timer checks are built only with CP0_TIMER_EN.
module tb_cp0_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_ena = 1'b0;
    logic [4:0]  w_addr = '0;
    logic [2:0]  w_sel = '0;
    logic [31:0] w_data = '0;
    logic [4:0]  r_addr = '0;
    logic [2:0]  r_sel = '0;
    logic [31:0] r_data;
    logic [5:0]  ext_int = '0;
    logic        w_cp0_update_ena = 1'b0;
    logic [4:0]  w_cp0_exccode = '0;
    logic        w_cp0_bd = 1'b0;
    logic        w_cp0_exl = 1'b0;
    logic [31:0] w_cp0_epc = '0;
    logic        w_cp0_badvaddr_ena = 1'b0;
    logic [31:0] w_cp0_badvaddr = '0;
    logic        cp0_cls_exl = 1'b0;
    logic [31:0] r_cp0_epc;
    logic [31:0] r_cp0_status;
    logic [31:0] r_cp0_cause;
    logic        cp0_int_req;

    cp0_regfile #(.STATUS_RST(32'h0040_0000), .COUNT_DIV(2)) dut (
        .clk(clk), .rst(rst),
        .w_ena(w_ena), .w_addr(w_addr), .w_sel(w_sel), .w_data(w_data),
        .r_addr(r_addr), .r_sel(r_sel), .r_data(r_data),
        .ext_int(ext_int),
        .w_cp0_update_ena(w_cp0_update_ena), .w_cp0_exccode(w_cp0_exccode),
        .w_cp0_bd(w_cp0_bd), .w_cp0_exl(w_cp0_exl), .w_cp0_epc(w_cp0_epc),
        .w_cp0_badvaddr_ena(w_cp0_badvaddr_ena), .w_cp0_badvaddr(w_cp0_badvaddr),
        .cp0_cls_exl(cp0_cls_exl),
        .r_cp0_epc(r_cp0_epc), .r_cp0_status(r_cp0_status), .r_cp0_cause(r_cp0_cause),
        .cp0_int_req(cp0_int_req)
    );

    always #5 clk = ~clk;

    typedef enum int {K_EPC, K_STATUS, K_CAUSE, K_INT, K_RDATA} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_cycle  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic expect_v(input string tag, input kind_t kind, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        w_ena  = 1'b1;
        w_addr = addr;
        w_data = data;
    endtask

    task automatic commit(input logic [4:0] code, input logic bd, input logic [31:0] epc);
        w_cp0_update_ena = 1'b1;
        w_cp0_exccode    = code;
        w_cp0_bd         = bd;
        w_cp0_exl        = 1'b1;
        w_cp0_epc        = epc;
    endtask

    // Advance one edge, compare every queued expectation, then drop the strobes.
    task automatic cycle();
        exp_t        e;
        logic [31:0] act;
        @(posedge clk);
        #1;
        n_cycle++;
        $display("cycle %0d: epc=%h status=%h cause=%h int=%b rdata=%h",
                 n_cycle, r_cp0_epc, r_cp0_status, r_cp0_cause, cp0_int_req, r_data);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_EPC:    act = r_cp0_epc;
                K_STATUS: act = r_cp0_status;
                K_CAUSE:  act = r_cp0_cause;
                K_INT:    act = {31'd0, cp0_int_req};
                default:  act = r_data;
            endcase
            check(e.tag, act, e.exp);
        end
        w_ena = 1'b0;
        w_sel = 3'd0;
        w_cp0_update_ena   = 1'b0;
        w_cp0_badvaddr_ena = 1'b0;
        cp0_cls_exl        = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_status", r_cp0_status, 32'h0040_0000);
        check("rst_cause", r_cp0_cause, 32'h0);
        check("rst_epc", r_cp0_epc, 32'h0);
        check("rst_int", {31'd0, cp0_int_req}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Park Compare far away so a timer build starts with TI clear.
        mtc0(5'd11, 32'hFFFF_FFFF); cycle();
        mtc0(5'd11, 32'hFFFF_FFFF); cycle();
        cycle();
        expect_v("idle_cause", K_CAUSE, 32'h0);
        cycle();

        commit(5'h0C, 1'b1, 32'hBFC0_1000);
        w_cp0_badvaddr_ena = 1'b1;
        w_cp0_badvaddr     = 32'h0000_0ABC;
        r_addr = 5'd8;
        expect_v("exc1_epc", K_EPC, 32'hBFC0_1000);
        expect_v("exc1_cause", K_CAUSE, 32'h8000_0030);
        expect_v("exc1_status", K_STATUS, 32'h0040_0002);
        expect_v("exc1_badvaddr", K_RDATA, 32'h0000_0ABC);
        cycle();

        commit(5'h04, 1'b0, 32'h0000_1234);
        r_addr = 5'd14;
        expect_v("exc2_epc_hold", K_EPC, 32'hBFC0_1000);
        expect_v("exc2_cause", K_CAUSE, 32'h8000_0010);
        expect_v("exc2_rd_epc", K_RDATA, 32'hBFC0_1000);
        cycle();

        cp0_cls_exl = 1'b1;
        r_addr = 5'd12;
        expect_v("eret_status", K_STATUS, 32'h0040_0000);
        expect_v("eret_epc", K_EPC, 32'hBFC0_1000);
        expect_v("eret_rd_status", K_RDATA, 32'h0040_0000);
        cycle();

        mtc0(5'd12, 32'h0000_0401);
        ext_int = 6'b000001;
        r_addr = 5'd13;
        expect_v("hw0_status", K_STATUS, 32'h0040_0401);
        expect_v("hw0_cause", K_CAUSE, 32'h8000_0410);
        expect_v("hw0_int", K_INT, 32'h1);
        expect_v("hw0_rd_cause", K_RDATA, 32'h8000_0410);
        cycle();

        mtc0(5'd12, 32'h0000_0403);
        expect_v("exl_mask_int", K_INT, 32'h0);
        cycle();

        mtc0(5'd12, 32'hFFFF_FFFF);
        expect_v("status_ro_bits", K_STATUS, 32'h0040_FF03);
        expect_v("status_ro_int", K_INT, 32'h0);
        cycle();

        mtc0(5'd12, 32'h0000_0401);
        expect_v("unmask_int", K_INT, 32'h1);
        cycle();

        ext_int = 6'b000000;
        expect_v("hw0_drop_cause", K_CAUSE, 32'h8000_0010);
        expect_v("hw0_drop_int", K_INT, 32'h0);
        cycle();

        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_v("cause_sw_only", K_CAUSE, 32'h8000_0310);
        expect_v("sw_masked_int", K_INT, 32'h0);
        cycle();

        mtc0(5'd12, 32'h0000_0301);
        expect_v("sw_int", K_INT, 32'h1);
        cycle();

        mtc0(5'd13, 32'h0000_0000);
        expect_v("sw_clear_cause", K_CAUSE, 32'h8000_0010);
        expect_v("sw_clear_int", K_INT, 32'h0);
        cycle();

        commit(5'h08, 1'b0, 32'h8000_0180);
        mtc0(5'd14, 32'h0000_DEAD);
        expect_v("prio_epc", K_EPC, 32'h8000_0180);
        expect_v("prio_cause", K_CAUSE, 32'h0000_0020);
        expect_v("prio_status", K_STATUS, 32'h0040_0303);
        cycle();

        cp0_cls_exl = 1'b1;
        mtc0(5'd12, 32'h0000_0003);
        expect_v("eret_vs_mtc0", K_STATUS, 32'h0040_0001);
        cycle();

        mtc0(5'd14, 32'h1111_2220);
        r_addr = 5'd14;
        expect_v("mtc0_epc", K_EPC, 32'h1111_2220);
        expect_v("mtc0_rd_epc", K_RDATA, 32'h1111_2220);
        cycle();

        mtc0(5'd14, 32'h5555_5555);
        w_sel = 3'd1;
        r_sel = 3'd1;
        expect_v("wsel_ignored", K_EPC, 32'h1111_2220);
        expect_v("rsel_zero", K_RDATA, 32'h0);
        cycle();

        r_sel = 3'd0;
        r_addr = 5'd5;
        expect_v("unmapped_rd", K_RDATA, 32'h0);
        cycle();

        mtc0(5'd12, 32'h0000_8001);
        ext_int = 6'b100000;
        expect_v("hw5_cause", K_CAUSE, 32'h0000_8020);
        expect_v("hw5_int", K_INT, 32'h1);
        cycle();

        ext_int = 6'b000000;
        expect_v("hw5_drop_cause", K_CAUSE, 32'h0000_0020);
        expect_v("hw5_drop_int", K_INT, 32'h0);
        cycle();

`ifdef CP0_TIMER_EN
        r_addr = 5'd9;
        mtc0(5'd9, 32'h0);
        expect_v("cnt_load", K_RDATA, 32'h0);
        cycle();
        mtc0(5'd11, 32'd5);
        expect_v("cnt_k1", K_RDATA, 32'h0);
        cycle();
        for (int k = 2; k <= 12; k++) begin
            expect_v($sformatf("cnt_k%0d", k), K_RDATA, 32'(k / 2));
            expect_v($sformatf("ti_cause_k%0d", k), K_CAUSE,
                     ((k >= 11) ? 32'h4000_0000 : 32'h0) |
                     ((k >= 12) ? 32'h0000_8000 : 32'h0) | 32'h0000_0020);
            expect_v($sformatf("ti_int_k%0d", k), K_INT, (k >= 12) ? 32'h1 : 32'h0);
            cycle();
        end
        mtc0(5'd11, 32'h0000_0100);
        expect_v("ti_clr_cause", K_CAUSE, 32'h0000_8020);
        expect_v("ti_clr_cnt", K_RDATA, 32'd6);
        cycle();
        expect_v("ti_clr_cause2", K_CAUSE, 32'h0000_0020);
        expect_v("ti_clr_int", K_INT, 32'h0);
        cycle();
`else
        r_addr = 5'd9;
        mtc0(5'd9, 32'd5);
        expect_v("count_off", K_RDATA, 32'h0);
        cycle();
        r_addr = 5'd11;
        mtc0(5'd11, 32'd5);
        expect_v("compare_off", K_RDATA, 32'h0);
        cycle();
`endif

        // Reset asserted between edges must clear state without waiting for a clock.
        r_addr = 5'd9;
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", r_data, 32'h0);
        check("arst_epc", r_cp0_epc, 32'h0);
        check("arst_status", r_cp0_status, 32'h0040_0000);
        check("arst_cause", r_cp0_cause, 32'h0);
        #20;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
